// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: op codes and response FSM states.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    // ALU control codes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_NONE = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    // IDLE: response register empty; HOLD: response register full
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : alu_pkg

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU: modulo arithmetic, logic ops, logical shifts by the
// full 32-bit operand B (amounts of 32 or more shift everything out).
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic shift_oor;

    // Result selection by op code; unused code 011 produces zero
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        result    = '0;
        shift_oor = (b >= DATA_W);
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SLL:  result = shift_oor ? '0 : (a << b[4:0]);
            OP_SUB:  result = a - b;
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = shift_oor ? '0 : (a >> b[4:0]);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule : alu_share_arbiter_alu

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU; the granted operation's result is held in a
// single response register with valid/ready hand-off to the consumer.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
);

    state_t            state_q, state_d;
    logic              last_id_q, last_id_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic              slot_free;
    logic              prio0, prio1;
    logic              acc0, acc1, accept;

    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]        alu_op;
    logic              alu_zero;

    // Grant: readies depend only on slot state, the other requester and priority
    always_comb begin
        slot_free = (state_q == IDLE) || rsp_ready;
        // Round-robin favours whoever was not served last; fixed mode favours 0
        prio0     = !RR_EN || last_id_q;
        prio1     = RR_EN && !last_id_q;
        req0_ready = !rst && slot_free && !(req1_valid && prio1);
        req1_ready = !rst && slot_free && !(req0_valid && prio0);
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        accept     = acc0 || acc1;
    end

    // Operand mux: route the granted requester into the shared ALU
    always_comb begin
        alu_a  = acc1 ? req1_a  : req0_a;
        alu_b  = acc1 ? req1_b  : req0_b;
        alu_op = acc1 ? req1_op : req0_op;
    end

    alu_share_arbiter_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Next state: fill on acceptance, drain on consumer ready, otherwise hold
    always_comb begin
        state_d      = state_q;
        last_id_d    = last_id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        unique case (state_q)
            IDLE:    if (accept)                 state_d = HOLD;
            HOLD:    if (rsp_ready && !accept)   state_d = IDLE;
            default:                             state_d = IDLE;
        endcase

        if (accept) begin
            last_id_d    = acc1;
            rsp_id_d     = acc1;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
        end
    end

    // State and response registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            last_id_q    <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_id_q    <= last_id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign rsp_valid  = (state_q == HOLD);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule : alu_share_arbiter

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: RR_EN, 1, arbitration mode (1 = round-robin, 0 = fixed priority to requester 0).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when valid also high.
REQ-006 req0_a  input  32  requester 0 operand A.
REQ-007 req0_b  input  32  requester 0 operand B.
REQ-008 req0_op  input  3  requester 0 ALU control code.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_op SHALL mirror REQ-004..REQ-008 for requester 1.
REQ-010 rsp_valid  output  1  response register holds a result.
REQ-011 rsp_ready  input  1  consumer takes response this cycle.
REQ-012 rsp_id  output  1  requester index owning the response.
REQ-013 rsp_result  output  32  registered ALU result.
REQ-014 rsp_zero  output  1  registered zero flag (rsp_result == 0).

Function
REQ-015 Op codes SHALL be: 000 add, 001 shift-left logical, 010 subtract, 100 xor, 101 shift-right logical, 110 or, 111 and; 011 yields result 0, zero 1.
REQ-016 Arithmetic SHALL be 32-bit modulo, no overflow/carry output; shift amount = full 32-bit operand B, amounts >= 32 yield 0.
REQ-017 FSM states SHALL be IDLE (response register empty) and HOLD (response register full).
REQ-018 Slot free SHALL be defined as state IDLE, or state HOLD with rsp_ready high (same-cycle drain and refill).
REQ-019 reqK_ready SHALL equal slot free AND NOT (other requester valid AND other requester has priority); reqK_ready SHALL NOT depend on reqK_valid.
REQ-020 Priority with both valid: RR_EN=1 -> requester not equal to last_id; RR_EN=0 -> requester 0 always.
REQ-021 At most one acceptance per cycle; acceptance = reqK_valid AND reqK_ready.
REQ-022 On acceptance the ALU result of that requester's operands SHALL be captured; rsp_valid, rsp_result, rsp_zero, rsp_id SHALL reflect it the next cycle (latency 1).
REQ-023 last_id SHALL update to the accepted requester index on acceptance only; idle cycles leave it unchanged.
REQ-024 Transitions: IDLE->HOLD on acceptance; HOLD->IDLE on rsp_ready without acceptance; HOLD->HOLD on rsp_ready with acceptance (new data) or on !rsp_ready (data unchanged).
REQ-025 While rsp_valid high and rsp_ready low, all rsp_* outputs SHALL remain stable.
REQ-026 rsp_ready high while rsp_valid low SHALL have no effect.
REQ-027 Full-throughput: with rsp_ready held high and requests always valid, one response per cycle SHALL be delivered.

Reset
REQ-028 On rst high at a clock edge: state IDLE, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_id 0, last_id 1.
REQ-029 Reset mid-operation SHALL discard any held response; no acceptance SHALL occur in a cycle where rst is high (req0_ready, req1_ready forced 0).

Structure
REQ-030 Package alu_pkg SHALL hold the 3-bit op-code constants and the IDLE/HOLD state enumeration.
REQ-031 One sub-module SHALL be instantiated: the existing combinational ALU, fed by a mux selecting the granted requester's operands and op code.
REQ-032 rsp_zero SHALL be taken from the ALU Zero output, registered alongside the result.

Verification
REQ-033 Single request: req0 a=5, b=3, op=010, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=2, rsp_zero=0, rsp_id=0.
REQ-034 Contention RR_EN=1: both valid every cycle after reset, rsp_ready=1 -> rsp_id sequence 0,1,0,1; RR_EN=0 -> 0,0,0,0 with req1_ready low.
REQ-035 Back-pressure: rsp_ready=0 for 3 cycles with req1 a=0xF0, b=0x0F, op=110 -> rsp_result=0x000000FF stable, both ready low; rsp_ready=1 -> next request accepted same cycle.
REQ-036 Boundaries: op=001 a=1 b=32 -> result 0, zero 1; op=000 a=0xFFFFFFFF b=1 -> result 0, zero 1; op=011 -> result 0, zero 1.
REQ-037 Reset in HOLD with rsp_ready=0 -> next cycle rsp_valid=0, rsp_result=0, then req0 and req1 both valid -> requester 0 granted first.
